// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin channel selector driving an external 8:1 mux
// Grants one requester, waits a cycle for the mux to settle, then holds the captured word.
module rr_sel_arbiter #(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    req,
    input  logic [DW-1:0] mux_out,
    output logic [2:0]    sel,
    output logic [7:0]    gnt,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [2:0]    o_ch,
    input  logic          o_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_ptr;
    logic [2:0]    r_sel;
    logic [7:0]    r_gnt;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [2:0]    r_ch;

    state_t        w_state_nxt;
    logic [2:0]    w_ptr_nxt;
    logic [2:0]    w_sel_nxt;
    logic [7:0]    w_gnt_nxt;
    logic          w_valid_nxt;
    logic [DW-1:0] w_data_nxt;
    logic [2:0]    w_ch_nxt;

    logic          w_found;
    logic [2:0]    w_idx;
    logic [2:0]    w_cand;

    // Scan from farthest to nearest so the first requester after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 8; k >= 1; k--) begin
            w_cand = r_ptr + 3'(k);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_ch_nxt    = r_ch;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = 8'b1 << w_idx;
                    w_state_nxt = SETTLE;
                end else begin
                    w_gnt_nxt = 8'h00;
                end
            end
            SETTLE: begin
                w_data_nxt  = mux_out;
                w_ch_nxt    = r_sel;
                w_valid_nxt = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (o_ready) begin
                    w_valid_nxt = 1'b0;
                    w_gnt_nxt   = 8'h00;
                    w_ptr_nxt   = r_ch;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 8'h00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // ptr resets to 7 so the first search after reset starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 3'd7;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    assign sel     = r_sel;
    assign gnt     = r_gnt;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ch    = r_ch;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - directed self-checking bench for rr_sel_arbiter
// Drives an 8:1 mux model from a table indexed by sel and checks hand-computed values.
module tb_rr_sel_arbiter;

    localparam int DW = 3;

    logic          clk;
    logic          rst_n;
    logic [7:0]    req;
    logic [DW-1:0] mux_out;
    logic [2:0]    sel;
    logic [7:0]    gnt;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [2:0]    o_ch;
    logic          o_ready;

    logic [DW-1:0] mux_tbl [8];

    int errors = 0;
    int checks = 0;

    rr_sel_arbiter #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mux_out (mux_out),
        .sel     (sel),
        .gnt     (gnt),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_ready (o_ready)
    );

    assign mux_out = mux_tbl[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] onehot_sel;
        @(posedge clk);
        #1;
        onehot_sel = 8'b1 << sel;
        check("gnt_onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
        check("gnt_matches_sel", {7'd0, (gnt == 8'h00) || (gnt == onehot_sel)}, 8'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"}, {5'd0, sel}, 8'h00);
        check({tag, "_gnt"}, gnt, 8'h00);
        check({tag, "_valid"}, {7'd0, o_valid}, 8'h00);
        check({tag, "_data"}, {5'd0, o_data}, 8'h00);
        check({tag, "_ch"}, {5'd0, o_ch}, 8'h00);
    endtask

    task automatic load_default_tbl();
        for (int i = 0; i < 8; i++) mux_tbl[i] = DW'((i + 1) % 8);
    endtask

    initial begin
        logic [2:0] ch;
        rst_n   = 1'b0;
        req     = 8'h00;
        o_ready = 1'b0;
        load_default_tbl();

        // Reset state
        tick();
        tick();
        check_all_zero("reset");

        // Single request on channel a
        rst_n   = 1'b1;
        req     = 8'h01;
        o_ready = 1'b1;
        tick();
        check("basic_sel", {5'd0, sel}, 8'd0);
        check("basic_gnt", gnt, 8'h01);
        check("basic_valid_lat", {7'd0, o_valid}, 8'd0);
        tick();
        check("basic_valid", {7'd0, o_valid}, 8'd1);
        check("basic_data", {5'd0, o_data}, 8'd1);
        check("basic_ch", {5'd0, o_ch}, 8'd0);
        tick();
        check("basic_done_valid", {7'd0, o_valid}, 8'd0);
        check("basic_done_gnt", gnt, 8'h00);
        req = 8'h00;

        // All requesters, constant ready: rotate 0..7,0 one per 3 cycles
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            ch = 3'(n);
            tick();
            check("rr_sel", {5'd0, sel}, {5'd0, ch});
            check("rr_gnt", gnt, 8'b1 << ch);
            tick();
            check("rr_valid", {7'd0, o_valid}, 8'd1);
            check("rr_ch", {5'd0, o_ch}, {5'd0, ch});
            check("rr_data", {5'd0, o_data}, 8'((n + 1) % 8));
            tick();
            check("rr_idle_valid", {7'd0, o_valid}, 8'd0);
        end

        // Complete channel 6, then 8'h41 must wrap past 7 to channel 0
        req = 8'h40;
        tick();
        check("wrap_g6", gnt, 8'h40);
        tick();
        check("wrap_ch6", {5'd0, o_ch}, 8'd6);
        tick();
        req = 8'h41;
        tick();
        check("wrap_gnt", gnt, 8'h01);
        check("wrap_sel", {5'd0, sel}, 8'd0);
        req = 8'h00;
        tick();
        check("deassert_valid", {7'd0, o_valid}, 8'd1);
        check("deassert_data", {5'd0, o_data}, 8'd1);
        tick();

        // Back-pressure with changing mux inputs and requests
        o_ready = 1'b0;
        req     = 8'h08;
        tick();
        check("hold_gnt0", gnt, 8'h08);
        tick();
        check("hold_data0", {5'd0, o_data}, 8'd4);
        for (int i = 0; i < 8; i++) mux_tbl[i] = 3'd5;
        req = 8'h02;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_valid", {7'd0, o_valid}, 8'd1);
            check("hold_data", {5'd0, o_data}, 8'd4);
            check("hold_ch", {5'd0, o_ch}, 8'd3);
            check("hold_sel", {5'd0, sel}, 8'd3);
            check("hold_gnt", gnt, 8'h08);
        end
        req     = 8'h00;
        o_ready = 1'b1;
        tick();
        check("hold_release_valid", {7'd0, o_valid}, 8'd0);
        check("hold_release_gnt", gnt, 8'h00);
        load_default_tbl();
        o_ready = 1'b0;

        // Asynchronous reset in HOLD, then first search starts at channel 0
        req = 8'h10;
        tick();
        tick();
        check("prereset_valid", {7'd0, o_valid}, 8'd1);
        check("prereset_ch", {5'd0, o_ch}, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        req = 8'h80;
        tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        tick();
        check("post_reset_gnt", gnt, 8'h80);
        check("post_reset_sel", {5'd0, sel}, 8'd7);
        tick();
        check("post_reset_valid", {7'd0, o_valid}, 8'd1);
        check("post_reset_data", {5'd0, o_data}, 8'd0);
        check("post_reset_ch", {5'd0, o_ch}, 8'd7);
        o_ready = 1'b1;
        req     = 8'h00;
        tick();

        // Idle with no requests; o_ready is ignored
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_gnt", gnt, 8'h00);
            check("idle_valid", {7'd0, o_valid}, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
